led_sequencer: RTL and testbench

Parametrised LED pattern generator, next generation of the board-level blinker used in the examples. It drives NUM_LEDS outputs from one clock through a prescaler and supports four runtime-selectable patterns, pause, and single-step. It also provides a per-transition tick pulse for chaining or debug. It sits directly between the board clock and the LED pins; it has no bus interface.

---
 rtl/led_sequencer.sv | 114 +++++++++++
 tb/tb_led_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator with four runtime patterns,
// pause, single-step and a per-transition tick pulse.
module led_sequencer #(
  parameter int unsigned DIV        = 27000000 / 6,
  parameter int unsigned NUM_LEDS   = 6,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  input  logic                step,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [NUM_LEDS-1:0] PAT_RST  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LEDS_RST = ACTIVE_LOW ? ~PAT_RST : PAT_RST;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mode_e               cur_mode_q, cur_mode_d;
  logic                dir_up_q, dir_up_d;
  logic [NUM_LEDS-1:0] leds_d;
  logic                tick_d;
  logic                fire_c;
  mode_e               mode_in_c;

  // State and output registers; reset shows LED0 lit in ROTATE.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pat_q      <= PAT_RST;
      cnt_q      <= '0;
      cur_mode_q <= MODE_ROTATE;
      dir_up_q   <= 1'b1;
      leds       <= LEDS_RST;
      tick       <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      cur_mode_q <= cur_mode_d;
      dir_up_q   <= dir_up_d;
      leds       <= leds_d;
      tick       <= tick_d;
    end
  end

  // Next-state: prescaler, mode reload on change, otherwise advance the pattern.
  always_comb begin
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    cur_mode_d = cur_mode_q;
    dir_up_d   = dir_up_q;
    tick_d     = 1'b0;
    mode_in_c  = mode_e'(mode);
    // Pause wins over a prescaler wrap; step only acts while paused.
    fire_c     = pause ? step : (cnt_q == CNT_LAST);

    if (fire_c) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (mode_in_c != cur_mode_q) begin
        cur_mode_d = mode_in_c;
        dir_up_d   = 1'b1;
        case (mode_in_c)
          MODE_ROTATE: pat_d = PAT_RST;
          MODE_BOUNCE: pat_d = PAT_RST;
          MODE_COUNT:  pat_d = '0;
          MODE_BLINK:  pat_d = '1;
          default:     pat_d = PAT_RST;
        endcase
      end else begin
        case (cur_mode_q)
          MODE_ROTATE: pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
          MODE_BOUNCE: begin
            // Turn around at each end so the endpoint is shown for one period.
            if (dir_up_q) begin
              if (pat_q[NUM_LEDS-1]) begin
                dir_up_d = 1'b0;
                pat_d    = pat_q >> 1;
              end else begin
                pat_d    = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_up_d = 1'b1;
                pat_d    = pat_q << 1;
              end else begin
                pat_d    = pat_q >> 1;
              end
            end
          end
          MODE_COUNT:  pat_d = pat_q + NUM_LEDS'(1);
          MODE_BLINK:  pat_d = ~pat_q;
          default:     pat_d = pat_q;
        endcase
      end
    end else if (!pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    leds_d = ACTIVE_LOW ? ~pat_d : pat_d;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (DIV=4, NUM_LEDS=6, active-low LEDs).
module tb_led_sequencer;

  logic       sys_clk;
  logic       sys_reset_n;
  logic [1:0] mode;
  logic       pause;
  logic       step;
  logic [5:0] leds;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] mode;
    logic       pause;
    logic       step;
    logic [5:0] leds;
    logic       tick;
  } vec_t;

  vec_t vecs[25];

  led_sequencer #(
    .DIV        (4),
    .NUM_LEDS   (6),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .mode        (mode),
    .pause       (pause),
    .step        (step),
    .leds        (leds),
    .tick        (tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one clock and settle just after the rising edge.
  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp_leds, input logic exp_tick);
    n_tests++;
    if (leds !== exp_leds || tick !== exp_tick) begin
      n_fail++;
      $display("FAIL %s: got leds=%b tick=%b, expected leds=%b tick=%b",
               name, leds, tick, exp_leds, exp_tick);
    end
  endtask

  initial begin
    logic [5:0] pat_m;
    logic [5:0] cnt_m;

    // Paused stepping through BOUNCE, BLINK mode sampling, COUNT start.
    vecs[0]  = '{2'd1, 1'b1, 1'b0, 6'b111110, 1'b0};
    vecs[1]  = '{2'd1, 1'b1, 1'b1, 6'b111110, 1'b1};
    vecs[2]  = '{2'd1, 1'b1, 1'b1, 6'b111101, 1'b1};
    vecs[3]  = '{2'd1, 1'b1, 1'b1, 6'b111011, 1'b1};
    vecs[4]  = '{2'd1, 1'b1, 1'b1, 6'b110111, 1'b1};
    vecs[5]  = '{2'd1, 1'b1, 1'b1, 6'b101111, 1'b1};
    vecs[6]  = '{2'd1, 1'b1, 1'b1, 6'b011111, 1'b1};
    vecs[7]  = '{2'd1, 1'b1, 1'b1, 6'b101111, 1'b1};
    vecs[8]  = '{2'd1, 1'b1, 1'b0, 6'b101111, 1'b0};
    vecs[9]  = '{2'd1, 1'b1, 1'b1, 6'b110111, 1'b1};
    vecs[10] = '{2'd1, 1'b1, 1'b1, 6'b111011, 1'b1};
    vecs[11] = '{2'd1, 1'b1, 1'b1, 6'b111101, 1'b1};
    vecs[12] = '{2'd1, 1'b1, 1'b1, 6'b111110, 1'b1};
    vecs[13] = '{2'd1, 1'b1, 1'b1, 6'b111101, 1'b1};
    vecs[14] = '{2'd3, 1'b1, 1'b0, 6'b111101, 1'b0};
    vecs[15] = '{2'd3, 1'b1, 1'b1, 6'b000000, 1'b1};
    vecs[16] = '{2'd3, 1'b1, 1'b1, 6'b111111, 1'b1};
    vecs[17] = '{2'd0, 1'b1, 1'b0, 6'b111111, 1'b0};
    vecs[18] = '{2'd3, 1'b1, 1'b1, 6'b000000, 1'b1};
    vecs[19] = '{2'd0, 1'b1, 1'b0, 6'b000000, 1'b0};
    vecs[20] = '{2'd3, 1'b1, 1'b1, 6'b111111, 1'b1};
    vecs[21] = '{2'd2, 1'b1, 1'b1, 6'b111111, 1'b1};
    vecs[22] = '{2'd2, 1'b1, 1'b1, 6'b111110, 1'b1};
    vecs[23] = '{2'd2, 1'b1, 1'b1, 6'b111101, 1'b1};
    vecs[24] = '{2'd2, 1'b1, 1'b1, 6'b111100, 1'b1};

    sys_reset_n = 1'b0;
    mode        = 2'd0;
    pause       = 1'b0;
    step        = 1'b0;
    repeat (2) cycle();
    check("reset", 6'b111110, 1'b0);
    sys_reset_n = 1'b1;

    // Free-running ROTATE: a tick every 4th edge, six ticks back to LED0.
    pat_m = 6'b000001;
    for (int k = 0; k < 6; k++) begin
      repeat (3) begin
        cycle();
        check("rotate_wait", ~pat_m, 1'b0);
      end
      pat_m = {pat_m[4:0], pat_m[5]};
      cycle();
      check("rotate_tick", ~pat_m, 1'b1);
    end
    check("rotate_wrap", 6'b111110, 1'b0 | tick);

    // Table of paused single-step vectors.
    for (int i = 0; i < 25; i++) begin
      mode  = vecs[i].mode;
      pause = vecs[i].pause;
      step  = vecs[i].step;
      cycle();
      check($sformatf("vec%0d", i), vecs[i].leds, vecs[i].tick);
    end

    // COUNT steps through to all ones and wraps to zero.
    for (int i = 4; i <= 64; i++) begin
      cnt_m = 6'(i);
      cycle();
      check("count_step", ~cnt_m, 1'b1);
    end

    // Pause with prescaler at 2, step once, then resume a full period.
    step  = 1'b0;
    pause = 1'b0;
    repeat (2) begin
      cycle();
      check("pre_pause", 6'b111111, 1'b0);
    end
    pause = 1'b1;
    repeat (20) begin
      cycle();
      check("paused", 6'b111111, 1'b0);
    end
    step = 1'b1;
    cycle();
    check("step_once", 6'b111110, 1'b1);
    step = 1'b0;
    cycle();
    check("step_release", 6'b111110, 1'b0);
    pause = 1'b0;
    repeat (3) begin
      cycle();
      check("resume_wait", 6'b111110, 1'b0);
    end
    cycle();
    check("resume_tick", 6'b111101, 1'b1);

    // Pause arriving exactly at cnt=DIV-1 suppresses the transition.
    repeat (3) begin
      cycle();
      check("run_to_last", 6'b111101, 1'b0);
    end
    pause = 1'b1;
    repeat (3) begin
      cycle();
      check("pause_at_last", 6'b111101, 1'b0);
    end
    pause = 1'b0;
    cycle();
    check("partial_period", 6'b111100, 1'b1);

    // Walk BOUNCE up to the top and one step back down.
    pause = 1'b1;
    mode  = 2'd1;
    step  = 1'b1;
    cycle();
    check("bounce_load", 6'b111110, 1'b1);
    pat_m = 6'b000001;
    repeat (5) begin
      pat_m = pat_m << 1;
      cycle();
      check("bounce_up", ~pat_m, 1'b1);
    end
    cycle();
    check("bounce_turn", 6'b101111, 1'b1);

    // Asynchronous reset between edges while tick is high.
    step = 1'b0;
    #2;
    sys_reset_n = 1'b0;
    #1;
    check("async_reset", 6'b111110, 1'b0);
    cycle();
    check("held_reset", 6'b111110, 1'b0);
    sys_reset_n = 1'b1;
    pause = 1'b0;
    mode  = 2'd0;
    repeat (3) begin
      cycle();
      check("post_reset_wait", 6'b111110, 1'b0);
    end
    cycle();
    check("post_reset_tick", 6'b111101, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
